// File: rtl/board_reset_controller.sv
// Purpose: sequences core reset/halt from raw board buttons (sync, debounce, min-width reset, run/halt FSM).
// Latency: raw button edge to output change is SYNC_STAGES + DEBOUNCE_CYCLES + 1 clock edges.
// Backpressure: none; buttons are free-running level inputs. Optional macro BOARD_RESET_CTRL_HALT_TOGGLE_EN selects toggle-mode halt.
module board_reset_controller #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int SYNC_STAGES       = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       reset_button,
  input  logic       halt_button,
  output logic       core_reset_n,
  output logic       core_halt,
  output logic [1:0] state,
  output logic [7:0] reset_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                       state_q;
  logic [HW-1:0]                hold_cnt;
  logic [1:0]                   btn_raw;
  logic [1:0][SYNC_STAGES-1:0]  sync_q;
  logic [1:0]                   btn_sync;
  logic [1:0]                   btn_deb;
  logic [1:0][CW-1:0]           deb_cnt;
  logic                         reset_deb;
  logic                         halt_deb;
  logic                         reset_deb_q;
  logic                         reset_press;
  logic                         halt_enter;
  logic                         halt_exit;

  // Bit 0 is the reset button, bit 1 the halt button throughout.
  assign btn_raw   = {halt_button, reset_button};
  assign btn_sync  = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
  assign reset_deb = btn_deb[0];
  assign halt_deb  = btn_deb[1];
  assign state     = state_q;

  // Metastability chains: shift each raw button through SYNC_STAGES flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      end
    end
  end

  // Debouncers: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_deb <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          btn_deb[i] <= btn_sync[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copy of the debounced reset level for press detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reset_deb_q <= 1'b0;
    end else begin
      reset_deb_q <= reset_deb;
    end
  end

  assign reset_press = reset_deb & ~reset_deb_q;

`ifdef BOARD_RESET_CTRL_HALT_TOGGLE_EN
  logic halt_deb_q;
  logic halt_press;

  // Delayed copy of the debounced halt level; each press flips run/halt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halt_deb_q <= 1'b0;
    end else begin
      halt_deb_q <= halt_deb;
    end
  end

  assign halt_press = halt_deb & ~halt_deb_q;
  assign halt_enter = halt_press;
  assign halt_exit  = halt_press;
`else
  // Level mode: the core is halted exactly while the debounced halt button is down.
  assign halt_enter = halt_deb;
  assign halt_exit  = ~halt_deb;
`endif

  // Run/halt FSM; outputs are loaded alongside the state so they change on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HOLD;
      hold_cnt     <= '0;
      core_reset_n <= 1'b0;
      core_halt    <= 1'b0;
      reset_count  <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt == HOLD_MAX) begin
            if (!reset_deb) begin
`ifdef BOARD_RESET_CTRL_HALT_TOGGLE_EN
              state_q      <= ST_RUN;
              core_reset_n <= 1'b1;
              core_halt    <= 1'b0;
`else
              state_q      <= halt_deb ? ST_HALTED : ST_RUN;
              core_reset_n <= 1'b1;
              core_halt    <= halt_deb;
`endif
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RUN, ST_HALTED: begin
          // A reset press always wins over a coincident halt event.
          if (reset_press) begin
            state_q      <= ST_HOLD;
            hold_cnt     <= '0;
            core_reset_n <= 1'b0;
            core_halt    <= 1'b0;
            if (reset_count != 8'hFF) begin
              reset_count <= reset_count + 8'd1;
            end
          end else if (state_q == ST_RUN && halt_enter) begin
            state_q   <= ST_HALTED;
            core_halt <= 1'b1;
          end else if (state_q == ST_HALTED && halt_exit) begin
            state_q   <= ST_RUN;
            core_halt <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_HOLD;
          hold_cnt     <= '0;
          core_reset_n <= 1'b0;
          core_halt    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_reset_controller.sv
// Directed bench for board_reset_controller with DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8, SYNC_STAGES=2.
// Button edges take 7 clock edges (2 sync + 4 debounce + 1 FSM) to reach the outputs.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_board_reset_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       reset_button;
  logic       halt_button;
  logic       core_reset_n;
  logic       core_halt;
  logic [1:0] state;
  logic [7:0] reset_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  always #5 clock = ~clock;

  board_reset_controller #(
    .DEBOUNCE_CYCLES  (4),
    .RESET_HOLD_CYCLES(8),
    .SYNC_STAGES      (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .reset_button(reset_button),
    .halt_button (halt_button),
    .core_reset_n(core_reset_n),
    .core_halt   (core_halt),
    .state       (state),
    .reset_count (reset_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input int rn, input int h, input int st, input int cnt);
    check({tag, "_core_reset_n"}, 32'(core_reset_n), rn);
    check({tag, "_core_halt"},    32'(core_halt),    h);
    check({tag, "_state"},        32'(state),        st);
    check({tag, "_reset_count"},  32'(reset_count),  cnt);
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int k;
    k = 0;
    while (32'(state) != s && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(state), s);
  endtask

  initial begin
    reset_n      = 1'b0;
    reset_button = 1'b0;
    halt_button  = 1'b0;
    step(3);
    check_outs("reset", 0, 0, 0, 0);

    // Power-up: 8-edge minimum hold, then RUN.
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("pwr_hold", 32'(core_reset_n), 0);
    end
    step(1);
    check_outs("pwr_run", 1, 0, 1, 0);

    // 3-cycle glitch is rejected.
    reset_button = 1'b1;
    step(3);
    reset_button = 1'b0;
    step(8);
    check_outs("glitch", 1, 0, 1, 0);

    // Held reset press: falls on edge 7, stays low while held.
    reset_button = 1'b1;
    step(6);
    check("press_lat6", 32'(core_reset_n), 1);
    step(1);
    exp_count = 1;
    check_outs("press_lat7", 0, 0, 0, exp_count);
    for (int i = 0; i < 23; i++) begin
      step(1);
      check("press_held", 32'(core_reset_n), 0);
    end
    reset_button = 1'b0;
    step(6);
    check("rel_lat6", 32'(core_reset_n), 0);
    step(1);
    check_outs("rel_run", 1, 0, 1, exp_count);

`ifdef BOARD_RESET_CTRL_HALT_TOGGLE_EN
    halt_button = 1'b1;
    step(6);
    check("tog_lat6", 32'(core_halt), 0);
    step(1);
    check_outs("tog_on", 1, 1, 2, exp_count);
    halt_button = 1'b0;
    step(10);
    check_outs("tog_rel", 1, 1, 2, exp_count);
    halt_button = 1'b1;
    step(7);
    check_outs("tog_off", 1, 0, 1, exp_count);
    halt_button = 1'b0;
    step(10);
    check_outs("tog_off_rel", 1, 0, 1, exp_count);
`else
    halt_button = 1'b1;
    step(6);
    check("lvl_lat6", 32'(core_halt), 0);
    step(1);
    check_outs("lvl_on", 1, 1, 2, exp_count);
    halt_button = 1'b0;
    step(7);
    check_outs("lvl_off", 1, 0, 1, exp_count);
    // Halt held through a reset: HOLD, then straight to HALTED.
    halt_button = 1'b1;
    step(7);
    check_outs("lvl_on2", 1, 1, 2, exp_count);
    reset_button = 1'b1;
    step(7);
    exp_count++;
    check_outs("lvl_rst", 0, 0, 0, exp_count);
    step(5);
    reset_button = 1'b0;
    step(7);
    check_outs("lvl_hold_exit", 1, 1, 2, exp_count);
    halt_button = 1'b0;
    step(7);
    check_outs("lvl_rel", 1, 0, 1, exp_count);
`endif

    // Simultaneous reset and halt press: reset wins, counted once.
    reset_button = 1'b1;
    halt_button  = 1'b1;
    step(7);
    exp_count++;
    check_outs("simul", 0, 0, 0, exp_count);
    step(10);
    reset_button = 1'b0;
    halt_button  = 1'b0;
    step(7);
    check_outs("simul_exit", 1, 0, 1, exp_count);

    // Async reset mid-HOLD (hold counter 5, reset debouncer counting).
    reset_button = 1'b1;
    step(7);
    exp_count++;
    check_outs("mid_press", 0, 0, 0, exp_count);
    reset_button = 1'b0;
    step(5);
    reset_n = 1'b0;
    #2;
    check_outs("async_rst", 0, 0, 0, 0);
    step(2);
    reset_n   = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("rerun_hold", 32'(core_reset_n), 0);
    end
    step(1);
    check_outs("rerun", 1, 0, 1, 0);

    // 260 button resets: count saturates at 255.
    for (int i = 0; i < 260; i++) begin
      reset_button = 1'b1;
      wait_state(0, 20, "sat_enter");
      reset_button = 1'b0;
      wait_state(1, 30, "sat_exit");
      if (exp_count < 255) exp_count++;
    end
    check_outs("sat", 1, 0, 1, exp_count);
    check("sat_255", 32'(reset_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_reset_controller.md
Name: board_reset_controller

Overview:
- Sequences the rvx core's reset and halt from raw, bouncing board push-buttons.
- Sits in each board top between the button pins and the core's reset_n/halt inputs, in the divided core clock domain.
- Provides metastability synchronisation, counter-based debouncing, a minimum-width reset pulse, and a run/halt state machine.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a button change is accepted (10 ms at 50 MHz); must be >= 1.
- RESET_HOLD_CYCLES, 16, minimum cycles core_reset_n is held low; must be >= 1.
- SYNC_STAGES, 2, flops in each button synchroniser; must be >= 2.

Ports:
- clock  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset for this block (power-on/board reset).
- reset_button  input  1  raw reset button, active-high, asynchronous.
- halt_button  input  1  raw halt button, active-high, asynchronous.
- core_reset_n  output  1  active-low reset to the core, registered.
- core_halt  output  1  halt to the core, registered.
- state  output  2  FSM state: 0 HOLD, 1 RUN, 2 HALTED.
- reset_count  output  8  number of button-initiated resets, saturating at 255.

Behaviour:
- Reset (reset_n=0, asynchronous): all synchroniser flops, debounced values and debounce counters clear to 0; state=HOLD; hold counter=0; core_reset_n=0; core_halt=0; reset_count=0. Deassertion of reset_n is taken synchronously at the next clock edge.
- Synchroniser: SYNC_STAGES-flop chain per button; the last stage gives btn_sync.
- Debouncer, one per button:
  - The counter clears whenever btn_sync == btn_deb.
  - Otherwise the counter increments.
  - When the counter is DEBOUNCE_CYCLES-1 and btn_sync still differs, btn_deb <= btn_sync and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles is ignored.
- Events: press = rising edge of btn_deb; release = falling edge, both detected against a 1-cycle delayed copy.
- Latency: from a raw button edge to the core output change is SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges (+1 for sampling alignment).
- HOLD:
  - core_reset_n=0, core_halt=0.
  - The hold counter increments and saturates at RESET_HOLD_CYCLES-1.
  - When saturated and reset_deb=0, go to RUN, or to HALTED under the level-mode rule below.
  - While the reset button is held, stay in HOLD indefinitely.
- RUN:
  - core_reset_n=1, core_halt=0.
  - A reset press goes to HOLD, clears the hold counter, and increments reset_count (saturating at 255).
  - A halt condition goes to HALTED.
- HALTED:
  - core_reset_n=1, core_halt=1.
  - A reset press goes to HOLD (halt dropped), same counting as in RUN.
  - A halt-exit condition goes to RUN.
- Priority: a simultaneous reset press and halt event resolves to the reset press.
- Output timing: core_reset_n and core_halt are dedicated flops loaded from the next-state decode, so they change on the same edge as state; no combinational outputs, no glitches.
- Halt events are ignored in HOLD, except for the level-mode entry rule.

Optional Feature:
- BOARD_RESET_CTRL_HALT_TOGGLE_EN defined: a halt press in RUN enters HALTED; a halt press in HALTED returns to RUN. Releases are ignored. Leaving HOLD always goes to RUN.
- Undefined (level mode): HALTED while halt_deb=1, RUN while halt_deb=0. Leaving HOLD with halt_deb=1 goes directly to HALTED.

Test Plan (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8, SYNC_STAGES=2):
- Power-up: release reset_n with both buttons at 0 -> core_reset_n=0 for 8 edges, then 1; state=1; reset_count=0; core_halt=0.
- Debounce: reset_button high for 3 cycles -> no change. Held high for 30 cycles -> core_reset_n falls at edge 7 after the press (2+4+1), reset_count=1, stays low while held. After release, core_reset_n=1 once debounced 0 and hold counter saturated.
- Halt, toggle build: press+release halt -> core_halt=1, state=2. Second press -> core_halt=0, state=1. Level build: core_halt follows halt_deb; halt held through a reset -> HOLD then straight to state=2.
- Simultaneous events: halt and reset pressed in the same cycle in RUN -> state=0, core_halt=0, core_reset_n=0, reset_count increments once.
- Mid-operation reset: assert reset_n during HOLD at hold counter 5 and while debounce counters are non-zero -> all outputs return to reset values immediately, without a clock. After release, the full 8-cycle hold repeats.
- Saturation: 260 debounced reset presses -> reset_count=255, no wrap.
